// File: rtl/pipeline_hazard_sched.sv
// Stall/flush scheduler for the 5-stage pipeline: arbitrates dmem wait, taken
// branch and load-use hazards into register enables, flushes and PC enable.
module pipeline_hazard_sched #(
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_req,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic [3:0]       enableFF,
  output logic [3:0]       resetFF,
  output logic             enablePC,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             busy
);

  localparam int BW = $clog2(LU_STALL + 1);

  typedef enum logic {RUN = 1'b0, LSTALL = 1'b1} state_t;

  state_t        state, state_nx;
  logic [BW-1:0] bub_left, bub_nx;
  logic          flush_ev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      bub_left  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nx;
      bub_left <= bub_nx;
      if (!enablePC && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_ev && flush_cnt != '1)  flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // dmem wait freezes everything, including a pending load-use countdown
  always_comb begin
    state_nx = state;
    bub_nx   = bub_left;
    if (dmem_busy) begin
      state_nx = state;
    end else if (branch_taken) begin
      state_nx = RUN;
      bub_nx   = '0;
    end else if (state == RUN && load_use_req) begin
      if (LU_STALL > 1) begin
        state_nx = LSTALL;
        bub_nx   = BW'(LU_STALL - 1);
      end
    end else if (state == LSTALL) begin
      bub_nx = bub_left - 1'b1;
      if (bub_left == BW'(1)) state_nx = RUN;
    end
  end

  always_comb begin
    enableFF = 4'b1111;
    resetFF  = 4'b0000;
    enablePC = 1'b1;
    flush_ev = 1'b0;
    if (!rst_n) begin
      resetFF  = 4'b1111;
      enablePC = 1'b0;
    end else if (dmem_busy) begin
      enableFF = 4'b0000;
      enablePC = 1'b0;
    end else if (branch_taken) begin
      resetFF  = 4'b1100;
      flush_ev = 1'b1;
    end else if ((state == RUN && load_use_req) || state == LSTALL) begin
      enableFF = 4'b0111;
      resetFF  = 4'b0100;
      enablePC = 1'b0;
    end
  end

  assign busy = (state == LSTALL);

endmodule

// File: tb/tb_pipeline_hazard_sched.sv
// Bench for pipeline_hazard_sched: three instances (LU_STALL 1/3/2) share the
// stimulus and are compared every cycle against a bubble-countdown model.
module tb_pipeline_hazard_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_use_req = 1'b0, branch_taken = 1'b0, dmem_busy = 1'b0;

  always #5 clk = ~clk;

  logic [3:0]  ef [3];
  logic [3:0]  rf [3];
  logic        epc[3];
  logic        bsy[3];
  logic [15:0] sc [3];
  logic [15:0] fc [3];
  logic [3:0]  sc4, fc4;

  pipeline_hazard_sched #(.LU_STALL(1), .CNT_W(16)) u_lu1 (
    .clk(clk), .rst_n(rst_n), .load_use_req(load_use_req), .branch_taken(branch_taken),
    .dmem_busy(dmem_busy), .enableFF(ef[0]), .resetFF(rf[0]), .enablePC(epc[0]),
    .stall_cnt(sc[0]), .flush_cnt(fc[0]), .busy(bsy[0]));

  pipeline_hazard_sched #(.LU_STALL(3), .CNT_W(16)) u_lu3 (
    .clk(clk), .rst_n(rst_n), .load_use_req(load_use_req), .branch_taken(branch_taken),
    .dmem_busy(dmem_busy), .enableFF(ef[1]), .resetFF(rf[1]), .enablePC(epc[1]),
    .stall_cnt(sc[1]), .flush_cnt(fc[1]), .busy(bsy[1]));

  pipeline_hazard_sched #(.LU_STALL(2), .CNT_W(4)) u_cnt4 (
    .clk(clk), .rst_n(rst_n), .load_use_req(load_use_req), .branch_taken(branch_taken),
    .dmem_busy(dmem_busy), .enableFF(ef[2]), .resetFF(rf[2]), .enablePC(epc[2]),
    .stall_cnt(sc4), .flush_cnt(fc4), .busy(bsy[2]));

  assign sc[2] = {12'b0, sc4};
  assign fc[2] = {12'b0, fc4};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int k, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0d expected %0d at %0t", nm, k, got, exp, $time);
    end
  endtask

  // model: remaining stall cycles (0 = running freely) and raw event counts
  int lu_p[3]  = '{1, 3, 2};
  int cmax[3]  = '{65535, 65535, 15};
  int rem[3];
  int m_stall[3];
  int m_flush[3];
  bit mvalid = 1'b0;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int e_ef, e_rf, e_pc;
      if (!rst_n)                              begin e_ef = 15; e_rf = 15; e_pc = 0; end
      else if (dmem_busy)                      begin e_ef = 0;  e_rf = 0;  e_pc = 0; end
      else if (branch_taken)                   begin e_ef = 15; e_rf = 12; e_pc = 1; end
      else if (rem[k] > 0 || load_use_req)     begin e_ef = 7;  e_rf = 4;  e_pc = 0; end
      else                                     begin e_ef = 15; e_rf = 0;  e_pc = 1; end
      chk("enableFF", k, int'(ef[k]), e_ef);
      chk("resetFF",  k, int'(rf[k]), e_rf);
      chk("enablePC", k, int'(epc[k]), e_pc);
      if (mvalid) begin
        chk("busy",      k, int'(bsy[k]), (rem[k] > 0) ? 1 : 0);
        chk("stall_cnt", k, int'(sc[k]), (m_stall[k] > cmax[k]) ? cmax[k] : m_stall[k]);
        chk("flush_cnt", k, int'(fc[k]), (m_flush[k] > cmax[k]) ? cmax[k] : m_flush[k]);
      end
      // advance model to the state after the coming rising edge
      if (!rst_n) begin
        rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end else begin
        if (e_pc == 0) m_stall[k]++;
        if (dmem_busy) ;
        else if (branch_taken) begin rem[k] = 0; m_flush[k]++; end
        else if (rem[k] > 0) rem[k]--;
        else if (load_use_req) rem[k] = lu_p[k] - 1;
      end
    end
    if (!rst_n) mvalid = 1'b1;
  end

  task automatic step(input logic l, input logic b, input logic d);
    load_use_req = l; branch_taken = b; dmem_busy = d;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    // T1 reset
    do_reset();
    load_use_req = 0; branch_taken = 0; dmem_busy = 0; #1;
    chk("t1_enableFF", 0, int'(ef[0]), 15);
    chk("t1_resetFF",  0, int'(rf[0]), 0);
    chk("t1_enablePC", 0, int'(epc[0]), 1);
    chk("t1_stall_cnt", 0, int'(sc[0]), 0);
    chk("t1_busy",     1, int'(bsy[1]), 0);

    // T2 single load-use, LU_STALL=1
    step(1, 0, 0);
    step(0, 0, 0);
    chk("t2_stall_cnt", 0, int'(sc[0]), 1);
    chk("t2_busy", 0, int'(bsy[0]), 0);

    // T3 LU_STALL=3 pulse
    do_reset();
    step(1, 0, 0);
    chk("t3_busy_c2", 1, int'(bsy[1]), 1);
    chk("t3_pc_c2",   1, int'(epc[1]), 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t3_stall_cnt", 1, int'(sc[1]), 3);
    chk("t3_busy_end",  1, int'(bsy[1]), 0);

    // T4 branch cancels stall on its second cycle
    do_reset();
    step(1, 0, 0);
    step(0, 1, 0);
    chk("t4_stall_cnt", 1, int'(sc[1]), 1);
    chk("t4_flush_cnt", 1, int'(fc[1]), 1);
    chk("t4_busy",      1, int'(bsy[1]), 0);
    step(0, 0, 0);

    // T5 dmem wait dominates a held branch
    do_reset();
    repeat (4) step(0, 1, 1);
    step(0, 1, 0);
    chk("t5_stall_cnt", 0, int'(sc[0]), 4);
    chk("t5_flush_cnt", 0, int'(fc[0]), 1);
    step(0, 0, 0);

    // dmem wait freezes a pending load-use countdown; reset abandons a stall
    do_reset();
    step(1, 0, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    rst_n = 1'b0;
    step(0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0);
    chk("rst_mid_busy", 1, int'(bsy[1]), 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);

    // T6 CNT_W=4 saturation
    do_reset();
    repeat (20) step(0, 0, 1);
    chk("t6_sat", 2, int'(sc4), 15);
    repeat (3) step(1, 0, 1);
    chk("t6_hold", 2, int'(sc4), 15);
    step(0, 0, 0);

    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
